// File: rtl/seg7_pkg.sv
// Segment patterns ({a..g}, active-high) and scan FSM encoding shared by
// display blocks.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C,
                                          SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4,
                                          SEG_3, SEG_2, SEG_1, SEG_0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/N_BIT_ALU.sv
// N-bit ALU: 00 ADD, 01 SUB, 10 AND, 11 OR; result wraps modulo 2^N.
module N_BIT_ALU #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   opcode,
  output logic [N-1:0] result
);

  always_comb begin
    case (opcode)
      2'b00:   result = A + B;
      2'b01:   result = A - B;
      2'b10:   result = A & B;
      default: result = A | B;
    endcase
  end

endmodule

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder with blanking enable.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       en_i,
  output logic [6:0] seg_o
);

  assign seg_o = en_i ? SEG_HEX[val_i] : SEG_BLANK;

endmodule

// File: rtl/alu_display_scanner.sv
// Scans NUM_DIGITS ALU slots through one shared ALU and decoder onto a
// multiplexed common-cathode 7-segment display.
module alu_display_scanner
  import seg7_pkg::*;
#(
  parameter int N_ALU        = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_digit,
  input  logic [N_ALU-1:0]      wr_A,
  input  logic [N_ALU-1:0]      wr_B,
  input  logic [1:0]            wr_opcode,
  input  logic                  wr_enable,
  input  logic                  scan_en,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IW-1:0]         digit_idx
);

  localparam int CMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef struct packed {
    logic [N_ALU-1:0] opa;
    logic [N_ALU-1:0] opb;
    logic [1:0]       op;
    logic             en;
  } slot_t;

  slot_t [NUM_DIGITS-1:0] slot_q;
  scan_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  sel_q, sel_d;
  slot_t                  cur;
  logic [N_ALU-1:0]       alu_res;
  logic                   show_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (wr_en && (int'(wr_digit) < NUM_DIGITS)) begin
      slot_q[wr_digit] <= '{opa: wr_A, opb: wr_B, op: wr_opcode, en: wr_enable};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!scan_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output regs are gated by scan_en too, so a pause blanks on the very next edge.
  assign cur      = slot_q[idx_q];
  assign show_now = (state_q == SHOW) && scan_en;

  N_BIT_ALU #(.N(N_ALU)) u_alu (
    .A      (cur.opa),
    .B      (cur.opb),
    .opcode (cur.op),
    .result (alu_res)
  );

  seg7_hex_decode u_dec (
    .val_i (alu_res[3:0]),
    .en_i  (show_now && cur.en),
    .seg_o (seg_d)
  );

  assign sel_d = show_now ? (NUM_DIGITS'(1) << idx_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign digit_sel = sel_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_alu_display_scanner.sv
// Randomized bench for alu_display_scanner against a frame-timing model.
module tb_alu_display_scanner;

  localparam int ND = 4;
  localparam int SH = 4;
  localparam int BL = 2;
  localparam int P  = SH + BL;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_digit;
  logic [3:0] wr_A, wr_B;
  logic [1:0] wr_opcode;
  logic       wr_enable;
  logic       scan_en;
  logic       a, b, c, d, e, f, g;
  logic [ND-1:0] digit_sel;
  logic [1:0]    digit_idx;

  alu_display_scanner #(
    .N_ALU(4), .NUM_DIGITS(ND), .SHOW_CYCLES(SH), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_digit(wr_digit), .wr_A(wr_A),
    .wr_B(wr_B), .wr_opcode(wr_opcode), .wr_enable(wr_enable), .scan_en(scan_en),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .digit_sel(digit_sel), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  logic [6:0] HEX [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // model: slot contents plus the edge at which the current scan run started
  int         n_cmp = 0, n_bad = 0;
  int         edge_no = 0, run_start = 0, start_idx = 0;
  bit         running = 0;
  logic [3:0] m_a [ND], m_b [ND];
  logic [1:0] m_op [ND];
  logic       m_en [ND];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int s);
    int r;
    case (m_op[s])
      2'b00:   r = (int'(m_a[s]) + int'(m_b[s])) % 16;
      2'b01:   r = (int'(m_a[s]) - int'(m_b[s]) + 16) % 16;
      2'b10:   r = int'(m_a[s] & m_b[s]);
      default: r = int'(m_a[s] | m_b[s]);
    endcase
    return m_en[s] ? HEX[r] : 7'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ND; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_en[i] = 1'b0;
    end
    running = 0;
    start_idx = 0;
  endfunction

  task automatic step(input logic we, input logic [1:0] wd, input logic [3:0] wa,
                      input logic [3:0] wb, input logic [1:0] wo, input logic wen,
                      input logic se);
    int k, dg;
    logic [ND-1:0] x_sel;
    logic [6:0]    x_seg;
    int            x_idx;
    @(negedge clk);
    wr_en = we; wr_digit = wd; wr_A = wa; wr_B = wb; wr_opcode = wo;
    wr_enable = wen; scan_en = se;
    @(posedge clk);
    edge_no++;
    x_sel = '0; x_seg = '0;
    if (running && se) begin
      k  = edge_no - run_start - 1;
      dg = (start_idx + k / P) % ND;
      if (k % P >= BL) begin
        x_sel = ND'(1) << dg;
        x_seg = seg_of(dg);
      end
      x_idx = (start_idx + (edge_no - run_start) / P) % ND;
    end else if (running) begin
      start_idx = (start_idx + (edge_no - run_start - 1) / P) % ND;
      running   = 0;
      x_idx     = start_idx;
    end else begin
      if (se) begin
        running   = 1;
        run_start = edge_no;
      end
      x_idx = start_idx;
    end
    if (we && int'(wd) < ND) begin
      m_a[wd] = wa; m_b[wd] = wb; m_op[wd] = wo; m_en[wd] = wen;
    end
    #1;
    chk("digit_sel", 32'(digit_sel), 32'(x_sel));
    chk("segs", 32'({a, b, c, d, e, f, g}), 32'(x_seg));
    chk("digit_idx", 32'(digit_idx), 32'(x_idx));
  endtask

  task automatic idle_steps(input int cnt, input logic se);
    for (int i = 0; i < cnt; i++) step(1'b0, 2'd0, 4'd0, 4'd0, 2'd0, 1'b0, se);
  endtask

  task automatic wait_sel(input logic [ND-1:0] target, input int budget);
    int i;
    i = 0;
    while (digit_sel !== target && i < budget) begin
      idle_steps(1, 1'b1);
      i++;
    end
    chk("wait_sel", 32'(digit_sel), 32'(target));
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_digit = 0; wr_A = 0; wr_B = 0;
    wr_opcode = 0; wr_enable = 0; scan_en = 0;
    model_clear();
    #2;
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_segs", 32'({a, b, c, d, e, f, g}), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_steps(2, 1'b0);

    // single slot: 3+4 shows "7"
    step(1'b1, 2'd0, 4'd3, 4'd4, 2'b00, 1'b1, 1'b0);
    wait_sel(4'b0001, 20);
    chk("seven", 32'({a, b, c, d, e, f, g}), 32'h70);
    idle_steps(2 * ND * P, 1'b1);

    // full rotation with a disabled slot 3
    step(1'b1, 2'd0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'd1, 4'h2, 4'h0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'd2, 4'hE, 4'h0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'd3, 4'h5, 4'h5, 2'b00, 1'b0, 1'b1);
    idle_steps(2 * ND * P, 1'b1);

    // wrap: F+2 shows "1"
    step(1'b1, 2'd0, 4'hF, 4'h2, 2'b00, 1'b1, 1'b1);
    wait_sel(4'b0001, 2 * ND * P);
    chk("wrap_one", 32'({a, b, c, d, e, f, g}), 32'h30);

    // live update of slot 0 mid-show
    step(1'b1, 2'd0, 4'h5, 4'h0, 2'b00, 1'b1, 1'b1);
    wait_sel(4'b0001, 2 * ND * P);
    step(1'b1, 2'd0, 4'h9, 4'h0, 2'b00, 1'b1, 1'b1);
    idle_steps(P, 1'b1);

    // pause during digit 2, then resume
    wait_sel(4'b0100, 2 * ND * P);
    idle_steps(1, 1'b1);
    idle_steps(3, 1'b0);
    idle_steps(BL + 3, 1'b1);
    chk("resume_sel", 32'(digit_sel), 32'b0100);

    // randomized writes, opcodes and pauses
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) == 0), 2'($urandom_range(3)), 4'($urandom),
           4'($urandom), 2'($urandom), ($urandom_range(4) != 0),
           ($urandom_range(19) != 0));
    end

    // async reset in the middle of a show
    wait_sel(4'b0001, 3 * ND * P);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", 32'(digit_sel), 32'd0);
    chk("arst_segs", 32'({a, b, c, d, e, f, g}), 32'd0);
    chk("arst_idx", 32'(digit_idx), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; scan_en = 1'b0; wr_en = 1'b0;
    idle_steps(4, 1'b0);
    // slots must be cleared: a scan now shows only blank digits
    idle_steps(ND * P + 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
